// File: rtl/ds1302_slave_if.sv
`default_nettype none
// ============================================================================
// Module      : ds1302_slave_if
// Description : DS1302 three-wire pin bundle (CE, SCLK, split SIO).
// Revision    : 1.0 - initial release
// ============================================================================
interface ds1302_slave_if;
    logic DS_RST;
    logic DS_SCLK;
    logic DS_SIO_IN;
    logic DS_SIO_OUT;
    logic DS_SIO_OE;

    modport master (
        output DS_RST,
        output DS_SCLK,
        output DS_SIO_IN,
        input  DS_SIO_OUT,
        input  DS_SIO_OE
    );

    modport slave (
        input  DS_RST,
        input  DS_SCLK,
        input  DS_SIO_IN,
        output DS_SIO_OUT,
        output DS_SIO_OE
    );
endinterface
`default_nettype wire

// File: rtl/ds1302_slave.sv
`default_nettype none
// ============================================================================
// Module      : ds1302_slave
// Description : DS1302 serial responder with BCD seconds/minutes/hours and WP.
// Revision    : 1.0 - initial release
// ============================================================================
module ds1302_slave #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  wire logic     CLK,
    input  wire logic     RST,
    ds1302_slave_if.slave bus,
    output logic [7:0]    Time_second,
    output logic [7:0]    Time_munite,
    output logic [7:0]    Time_hour
);

    localparam int unsigned c_PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_MAX = c_PRESC_W'(CLK_HZ - 1);

    localparam logic [2:0] c_S_IDLE   = 3'd0;
    localparam logic [2:0] c_S_CMD    = 3'd1;
    localparam logic [2:0] c_S_WDATA  = 3'd2;
    localparam logic [2:0] c_S_RDATA  = 3'd3;
    localparam logic [2:0] c_S_IGNORE = 3'd4;

    localparam logic [4:0] c_ADDR_SEC   = 5'd0;
    localparam logic [4:0] c_ADDR_MIN   = 5'd1;
    localparam logic [4:0] c_ADDR_HR    = 5'd2;
    localparam logic [4:0] c_ADDR_WP    = 5'd7;
    localparam logic [4:0] c_ADDR_BURST = 5'd31;

    // Returns {carry, next}; no correction of invalid BCD digits.
    function automatic logic [8:0] f_bcd_inc(input logic [7:0] v, input logic [7:0] vmax);
        if (v == vmax)
            f_bcd_inc = 9'h100;
        else if (v[3:0] == 4'h9)
            f_bcd_inc = {1'b0, v[7:4] + 4'd1, 4'h0};
        else
            f_bcd_inc = {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    logic       r_ce_s1, r_ce_s2;
    logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
    logic       r_sio_s1, r_sio_s2;
    logic [2:0] r_state;
    logic [3:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [4:0] r_addr;
    logic       r_armed;
    logic       r_sio_out, r_sio_oe;
    logic       r_wp;
    logic [c_PRESC_W-1:0] r_presc;

    logic       w_sclk_rise, w_sclk_fall;
    logic [7:0] w_shift_in;
    logic [4:0] w_cmd_addr;
    logic [7:0] w_rd_data;
    logic       w_commit, w_wr_ok;
    logic       w_wr_sec, w_wr_min, w_wr_hr, w_wr_wp;
    logic       w_tick, w_run;
    logic [8:0] w_sec_inc, w_min_inc, w_hr_inc;

    // CE synchronizer resets high so a transaction in flight at reset is
    // ignored until CE has been seen low.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ce_s1   <= 1'b1;
            r_ce_s2   <= 1'b1;
            r_sclk_s1 <= 1'b0;
            r_sclk_s2 <= 1'b0;
            r_sclk_d  <= 1'b0;
            r_sio_s1  <= 1'b0;
            r_sio_s2  <= 1'b0;
        end else begin
            r_ce_s1   <= bus.DS_RST;
            r_ce_s2   <= r_ce_s1;
            r_sclk_s1 <= bus.DS_SCLK;
            r_sclk_s2 <= r_sclk_s1;
            r_sclk_d  <= r_sclk_s2;
            r_sio_s1  <= bus.DS_SIO_IN;
            r_sio_s2  <= r_sio_s1;
        end
    end

    assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
    assign w_shift_in  = {r_sio_s2, r_shift[7:1]};
    assign w_cmd_addr  = w_shift_in[5:1];

    always_comb begin
        w_rd_data = 8'h00;
        case (w_cmd_addr)
            c_ADDR_SEC: w_rd_data = Time_second;
            c_ADDR_MIN: w_rd_data = Time_munite;
            c_ADDR_HR:  w_rd_data = Time_hour;
            c_ADDR_WP:  w_rd_data = {r_wp, 7'b0};
            default:    w_rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= c_S_IDLE;
            r_bit_cnt <= 4'd0;
            r_shift   <= 8'h00;
            r_addr    <= 5'd0;
            r_armed   <= 1'b0;
            r_sio_oe  <= 1'b0;
            r_sio_out <= 1'b0;
        end else if (!r_ce_s2) begin
            r_state   <= c_S_IDLE;
            r_bit_cnt <= 4'd0;
            r_armed   <= 1'b1;
            r_sio_oe  <= 1'b0;
            r_sio_out <= 1'b0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (r_armed) begin
                        r_state   <= c_S_CMD;
                        r_bit_cnt <= 4'd0;
                        r_armed   <= 1'b0;
                    end
                end
                c_S_CMD: begin
                    if (w_sclk_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7) begin
                            r_bit_cnt <= 4'd0;
                            r_addr    <= w_cmd_addr;
                            if (!w_shift_in[7] || w_shift_in[6] || (w_cmd_addr == c_ADDR_BURST)) begin
                                r_state <= c_S_IGNORE;
                            end else if (w_shift_in[0]) begin
                                r_shift <= w_rd_data;
                                r_state <= c_S_RDATA;
                            end else begin
                                r_state <= c_S_WDATA;
                            end
                        end
                    end
                end
                c_S_WDATA: begin
                    if (w_sclk_rise) begin
                        r_shift   <= w_shift_in;
                        r_bit_cnt <= r_bit_cnt + 4'd1;
                        if (r_bit_cnt == 4'd7)
                            r_state <= c_S_IGNORE;
                    end
                end
                c_S_RDATA: begin
                    if (w_sclk_fall) begin
                        if (r_bit_cnt < 4'd8) begin
                            r_sio_oe  <= 1'b1;
                            r_sio_out <= r_shift[0];
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end else begin
                            r_sio_oe  <= 1'b0;
                            r_sio_out <= 1'b0;
                            r_state   <= c_S_IGNORE;
                        end
                    end
                end
                c_S_IGNORE: r_state <= c_S_IGNORE;
                default:    r_state <= c_S_IDLE;
            endcase
        end
    end

    assign bus.DS_SIO_OUT = r_sio_out;
    assign bus.DS_SIO_OE  = r_sio_oe;

    // Commit lands on the same CLK as the 16th synchronized rise.
    assign w_commit = (r_state == c_S_WDATA) && r_ce_s2 && w_sclk_rise && (r_bit_cnt == 4'd7);
    assign w_wr_ok  = w_commit && (!r_wp || (r_addr == c_ADDR_WP));
    assign w_wr_sec = w_wr_ok && (r_addr == c_ADDR_SEC);
    assign w_wr_min = w_wr_ok && (r_addr == c_ADDR_MIN);
    assign w_wr_hr  = w_wr_ok && (r_addr == c_ADDR_HR);
    assign w_wr_wp  = w_wr_ok && (r_addr == c_ADDR_WP);

    assign w_tick    = (r_presc == c_PRESC_MAX);
    assign w_run     = w_tick && !Time_second[7];
    assign w_sec_inc = f_bcd_inc({1'b0, Time_second[6:0]}, 8'h59);
    assign w_min_inc = f_bcd_inc(Time_munite, 8'h59);
    assign w_hr_inc  = f_bcd_inc(Time_hour, 8'h23);

    always_ff @(posedge CLK) begin
        if (RST) begin
            Time_second <= 8'h80;
            Time_munite <= 8'h00;
            Time_hour   <= 8'h00;
            r_wp        <= 1'b1;
            r_presc     <= '0;
        end else begin
            if (w_wr_sec || w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + 1'b1;

            // Host writes take priority; untouched registers still carry.
            if (w_wr_sec)
                Time_second <= w_shift_in;
            else if (w_run)
                Time_second <= {Time_second[7], 7'h00} | (w_sec_inc[7:0] & 8'h7F);

            if (w_wr_min)
                Time_munite <= w_shift_in;
            else if (w_run && w_sec_inc[8])
                Time_munite <= w_min_inc[7:0];

            if (w_wr_hr)
                Time_hour <= {1'b0, w_shift_in[6:0]};
            else if (w_run && w_sec_inc[8] && w_min_inc[8])
                Time_hour <= w_hr_inc[7:0] & 8'h7F;

            if (w_wr_wp)
                r_wp <= w_shift_in[7];
        end
    end

endmodule
`default_nettype wire
